// File: rtl/if_prefetch_stage_pkg.sv
// Shared types for the instruction-fetch stage: branch bus and fetch-to-decode bus layouts.
// Latency: n/a (types and a pure combinational helper only).
// Backpressure: n/a.
package if_prefetch_stage_pkg;

    localparam int BR_BUS_WD       = 34;
    localparam int FS_TO_DS_BUS_WD = 65;

    // {br_stall, br_taken, br_target}
    typedef struct packed {
        logic        stall;
        logic        taken;
        logic [31:0] target;
    } br_bus_t;

    // {adef, inst, pc}
    typedef struct packed {
        logic        adef;
        logic [31:0] inst;
        logic [31:0] pc;
    } fs_to_ds_t;

    // Redirect priority: exception, then ertn, then taken branch.
    function automatic logic [31:0] redirect_target(
        input logic        ex,
        input logic        ertn,
        input logic [31:0] ex_entry,
        input logic [31:0] ertn_entry,
        input logic [31:0] br_target
    );
        if (ex) begin
            return ex_entry;
        end
        if (ertn) begin
            return ertn_entry;
        end
        return br_target;
    endfunction

endpackage

// File: rtl/if_prefetch_stage_fetch_fifo.sv
// Synchronous FIFO with single-cycle flush; head data is a registered-array read.
// Latency: a push is visible at the head the cycle after it is written.
// Backpressure: push ignored when full unless a pop happens the same cycle; pop ignored when empty.
// Ports: clk/reset, flush_i, push_i/push_dat_i, pop_i, head_dat_o, count_o.
module if_prefetch_stage_fetch_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       flush_i,
    input  logic                       push_i,
    input  logic [WIDTH-1:0]           push_dat_i,
    input  logic                       pop_i,
    output logic [WIDTH-1:0]           head_dat_o,
    output logic [$clog2(DEPTH+1)-1:0] count_o
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    rd_ptr_q, wr_ptr_q;
    logic [CW-1:0]    count_q;
    logic             do_push, do_pop;

    // Pointers wrap explicitly so DEPTH need not be a power of two.
    function automatic logic [AW-1:0] next_ptr(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
    endfunction

    assign do_pop     = pop_i && (count_q != '0);
    assign do_push    = push_i && ((count_q != CW'(DEPTH)) || do_pop);
    assign head_dat_o = mem_q[rd_ptr_q];
    assign count_o    = count_q;

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_dat_i;
        end
    end

    always_ff @(posedge clk) begin
        if (reset || flush_i) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= next_ptr(wr_ptr_q);
            end
            if (do_pop) begin
                rd_ptr_q <= next_ptr(rd_ptr_q);
            end
            count_q <= count_q + CW'(do_push) - CW'(do_pop);
        end
    end

endmodule

// File: rtl/if_prefetch_stage.sv
// Pre-IF + IF stage: multi-outstanding SRAM-like fetch into an instruction queue feeding decode.
// Latency: data_ok in cycle T presents the instruction to decode in T+1; first request the cycle after reset.
// Backpressure: requests stop when outstanding or queue credit runs out; decode stalls only fill the queue.
// Ports: clk/reset, ds_allowin, br_bus, ws_ex/ws_ertn + entries, fs_to_ds_valid/bus, inst_sram_* request/response.
module if_prefetch_stage
    import if_prefetch_stage_pkg::*;
#(
    parameter logic [31:0] PC_RESET        = 32'h1c00_0000,
    parameter int          MAX_OUTSTANDING = 2,
    parameter int          IBUF_DEPTH      = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       ds_allowin,
    input  logic [BR_BUS_WD-1:0]       br_bus,
    input  logic                       ws_ex,
    input  logic                       ws_ertn,
    input  logic [31:0]                ex_entry,
    input  logic [31:0]                ertn_entry,
    output logic                       fs_to_ds_valid,
    output logic [FS_TO_DS_BUS_WD-1:0] fs_to_ds_bus,
    output logic                       inst_sram_en,
    output logic [3:0]                 inst_sram_wen,
    output logic [1:0]                 inst_sram_size,
    output logic [31:0]                inst_sram_addr,
    output logic [31:0]                inst_sram_wdata,
    input  logic                       inst_sram_addr_ok,
    input  logic                       inst_sram_data_ok,
    input  logic [31:0]                inst_sram_rdata
);

    localparam int OW = $clog2(MAX_OUTSTANDING + 1);
    localparam int IW = $clog2(IBUF_DEPTH + 1);

    br_bus_t     br;
    logic        redirect;
    logic [31:0] redirect_pc;

    logic [31:0]   pc_q, pc_d;
    logic [OW-1:0] outstanding_q, outstanding_d;
    logic [OW-1:0] discard_q, discard_d;
    logic          adef_hold_q, adef_hold_d;

    logic          credit, aligned, accept, rsp_cnt, rsp_live, adef_push;
    logic [OW-1:0] pcq_count;
    logic [31:0]   pcq_head;
    logic [IW-1:0] ibuf_count;
    fs_to_ds_t     ibuf_push_dat;
    logic [FS_TO_DS_BUS_WD-1:0] ibuf_head;

    assign br          = br_bus;
    assign redirect    = ws_ex || ws_ertn || br.taken;
    assign redirect_pc = redirect_target(ws_ex, ws_ertn, ex_entry, ertn_entry, br.target);

    // Queue credit counts in-flight requests (including ones to be discarded) so the
    // instruction queue can never overflow when their data lands.
    assign credit = !br.stall && !redirect && !adef_hold_q
                 && (32'(outstanding_q) < 32'(MAX_OUTSTANDING))
                 && ((32'(ibuf_count) + 32'(outstanding_q)) < 32'(IBUF_DEPTH));

    assign aligned   = (pc_q[1:0] == 2'b00);
    assign accept    = inst_sram_en && inst_sram_addr_ok;
    // A response with nothing outstanding is ignored rather than underflowing the counters.
    assign rsp_cnt   = inst_sram_data_ok && (outstanding_q != '0);
    assign rsp_live  = rsp_cnt && (discard_q == '0) && !redirect && (pcq_count != '0);
    // A misaligned pc waits for the pipe to drain so the fault stays in program order.
    assign adef_push = !reset && credit && !aligned && (outstanding_q == '0);

    assign inst_sram_en    = !reset && credit && aligned;
    assign inst_sram_wen   = 4'h0;
    assign inst_sram_size  = 2'b10;
    assign inst_sram_addr  = pc_q;
    assign inst_sram_wdata = 32'h0;

    assign fs_to_ds_valid = !reset && (ibuf_count != '0) && !redirect;
    assign fs_to_ds_bus   = ibuf_head;

    always_comb begin
        ibuf_push_dat = '{adef: 1'b1, inst: 32'h0, pc: pc_q};
        if (rsp_live) begin
            ibuf_push_dat = '{adef: 1'b0, inst: inst_sram_rdata, pc: pcq_head};
        end
    end

    always_comb begin
        pc_d          = pc_q;
        outstanding_d = outstanding_q + OW'(accept) - OW'(rsp_cnt);
        discard_d     = discard_q;
        adef_hold_d   = adef_hold_q;
        if (redirect) begin
            pc_d        = redirect_pc;
            // Every request still in flight belongs to the abandoned path.
            discard_d   = outstanding_q + OW'(accept) - OW'(rsp_cnt);
            adef_hold_d = 1'b0;
        end else begin
            if (accept) begin
                pc_d = pc_q + 32'd4;
            end
            if (rsp_cnt && (discard_q != '0)) begin
                discard_d = discard_q - OW'(1);
            end
            if (adef_push) begin
                adef_hold_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q          <= PC_RESET;
            outstanding_q <= '0;
            discard_q     <= '0;
            adef_hold_q   <= 1'b0;
        end else begin
            pc_q          <= pc_d;
            outstanding_q <= outstanding_d;
            discard_q     <= discard_d;
            adef_hold_q   <= adef_hold_d;
        end
    end

    if_prefetch_stage_fetch_fifo #(
        .WIDTH (32),
        .DEPTH (MAX_OUTSTANDING)
    ) u_pc_queue (
        .clk        (clk),
        .reset      (reset),
        .flush_i    (redirect),
        .push_i     (accept),
        .push_dat_i (pc_q),
        .pop_i      (rsp_live),
        .head_dat_o (pcq_head),
        .count_o    (pcq_count)
    );

    if_prefetch_stage_fetch_fifo #(
        .WIDTH (FS_TO_DS_BUS_WD),
        .DEPTH (IBUF_DEPTH)
    ) u_inst_queue (
        .clk        (clk),
        .reset      (reset),
        .flush_i    (redirect),
        .push_i     (rsp_live || adef_push),
        .push_dat_i (ibuf_push_dat),
        .pop_i      (fs_to_ds_valid && ds_allowin),
        .head_dat_o (ibuf_head),
        .count_o    (ibuf_count)
    );

endmodule

// File: tb/tb_if_prefetch_stage.sv
// Bench for if_prefetch_stage: randomized SRAM/decode/redirect traffic with a program-order scoreboard.
// Latency: n/a.
// Backpressure: SRAM addr_ok/data_ok and ds_allowin are driven from percentage knobs.
module tb_if_prefetch_stage;
    import if_prefetch_stage_pkg::*;

    localparam logic [31:0] PC_RESET   = 32'h1c00_0000;
    localparam int          MAX_OUT    = 2;
    localparam int          IBUF_DEPTH = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        ds_allowin;
    logic [33:0] br_bus;
    logic        ws_ex, ws_ertn;
    logic [31:0] ex_entry, ertn_entry;
    logic        fs_to_ds_valid;
    logic [64:0] fs_to_ds_bus;
    logic        inst_sram_en;
    logic [3:0]  inst_sram_wen;
    logic [1:0]  inst_sram_size;
    logic [31:0] inst_sram_addr, inst_sram_wdata;
    logic        inst_sram_addr_ok, inst_sram_data_ok;
    logic [31:0] inst_sram_rdata;

    always #5 clk = ~clk;

    if_prefetch_stage #(
        .PC_RESET        (PC_RESET),
        .MAX_OUTSTANDING (MAX_OUT),
        .IBUF_DEPTH      (IBUF_DEPTH)
    ) dut (
        .clk               (clk),
        .reset             (reset),
        .ds_allowin        (ds_allowin),
        .br_bus            (br_bus),
        .ws_ex             (ws_ex),
        .ws_ertn           (ws_ertn),
        .ex_entry          (ex_entry),
        .ertn_entry        (ertn_entry),
        .fs_to_ds_valid    (fs_to_ds_valid),
        .fs_to_ds_bus      (fs_to_ds_bus),
        .inst_sram_en      (inst_sram_en),
        .inst_sram_wen     (inst_sram_wen),
        .inst_sram_size    (inst_sram_size),
        .inst_sram_addr    (inst_sram_addr),
        .inst_sram_wdata   (inst_sram_wdata),
        .inst_sram_addr_ok (inst_sram_addr_ok),
        .inst_sram_data_ok (inst_sram_data_ok),
        .inst_sram_rdata   (inst_sram_rdata)
    );

    typedef struct { logic [31:0] addr; int acc_cyc; } req_t;
    typedef struct { int cyc; logic [64:0] bus; } ds_log_t;

    req_t        pend[$];      // accepted requests awaiting data_ok, in order
    logic [64:0] exp_q[$];     // expected decode stream from the current path
    ds_log_t     ds_log[$];
    logic [31:0] acc_log[$];

    int cyc = 0;
    int n_checks = 0;
    int n_pass = 0;
    int addr_pct, data_pct, allow_pct, stall_pct, lat_min;
    logic [31:0] stream_pc, next_req_pc;
    bit  stream_adef;
    bit  redir_now;
    int  adef_seen = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'h0000_3c3c;
    endfunction

    task automatic check(input string name, input logic [64:0] act, input logic [64:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic push_expected(input int n);
        for (int i = 0; i < n; i++) begin
            exp_q.push_back({1'b0, mem_word(stream_pc), stream_pc});
            stream_pc = stream_pc + 32'd4;
        end
    endtask

    // Program-order model: after a redirect the decode stream restarts at the target;
    // a misaligned target yields one fault entry and nothing more until the next redirect.
    task automatic model_redirect(input logic [31:0] tgt);
        exp_q.delete();
        stream_pc   = tgt;
        stream_adef = (tgt[1:0] != 2'b00);
        next_req_pc = tgt;
        if (stream_adef) exp_q.push_back({1'b1, 32'h0, tgt});
        else             push_expected(8);
    endtask

    task automatic drive(input bit ex, input bit ertn, input bit br, input bit stall_f,
                         input logic [31:0] t_br, input logic [31:0] t_ex, input logic [31:0] t_ertn);
        bit stall_b;
        @(posedge clk); #1;
        inst_sram_data_ok = 1'b0;
        inst_sram_rdata   = $urandom();
        if (pend.size() != 0 && (cyc - pend[0].acc_cyc) >= lat_min &&
            int'($urandom_range(99)) < data_pct) begin
            inst_sram_data_ok = 1'b1;
            inst_sram_rdata   = mem_word(pend[0].addr);
            void'(pend.pop_front());
        end
        inst_sram_addr_ok = int'($urandom_range(99)) < addr_pct;
        ds_allowin        = int'($urandom_range(99)) < allow_pct;
        stall_b           = stall_f || (int'($urandom_range(99)) < stall_pct);
        ws_ex      = ex;
        ws_ertn    = ertn;
        br_bus     = {stall_b, br, t_br};
        ex_entry   = t_ex;
        ertn_entry = t_ertn;
        redir_now  = ex || ertn || br;
        if (redir_now) model_redirect(ex ? t_ex : (ertn ? t_ertn : t_br));
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0);
    endtask

    task automatic settle();
        @(negedge clk); #1;
    endtask

    function automatic logic [31:0] rand_target();
        logic [31:0] t;
        t = 32'h1c00_0000 + ($urandom_range(1023) << 2);
        if ($urandom_range(9) == 0) t = t + $urandom_range(3, 1);
        return t;
    endfunction

    // Monitor: SRAM request rules, request address order, and decode stream vs scoreboard.
    always @(negedge clk) begin
        if (!reset) begin
            if (inst_sram_en) begin
                check("en_blocked_by_stall_or_redirect", {63'h0, redir_now, br_bus[33]}, 65'h0);
                check("en_addr_aligned", {63'h0, inst_sram_addr[1:0]}, 65'h0);
            end
            if (redir_now) check("valid_low_in_redirect", {64'h0, fs_to_ds_valid}, 65'h0);
            if (inst_sram_en && inst_sram_addr_ok) begin
                check("req_addr", {33'h0, inst_sram_addr}, {33'h0, next_req_pc});
                next_req_pc = next_req_pc + 32'd4;
                pend.push_back('{inst_sram_addr, cyc});
                acc_log.push_back(inst_sram_addr);
                check("outstanding_bound", {64'h0, pend.size() <= MAX_OUT}, 65'h1);
            end
            if (fs_to_ds_valid && ds_allowin) begin
                ds_log.push_back('{cyc, fs_to_ds_bus});
                if (fs_to_ds_bus[64]) adef_seen++;
                if (exp_q.size() == 0) begin
                    n_checks++;
                    $display("FAIL ds_unexpected: got %h expected no entry (cycle %0d)", fs_to_ds_bus, cyc);
                end else begin
                    check("ds_bus", fs_to_ds_bus, exp_q.pop_front());
                    if (!stream_adef && exp_q.size() < 8) push_expected(8);
                end
            end
        end
    end

    initial begin
        int c0, a0, p0, s0;
        reset = 1'b1; ds_allowin = 1'b0; br_bus = '0; ws_ex = 1'b0; ws_ertn = 1'b0;
        ex_entry = '0; ertn_entry = '0; inst_sram_addr_ok = 1'b0; inst_sram_data_ok = 1'b0;
        inst_sram_rdata = '0; redir_now = 1'b0;
        addr_pct = 100; data_pct = 100; allow_pct = 100; stall_pct = 0; lat_min = 1;
        stream_pc = PC_RESET; stream_adef = 1'b0; next_req_pc = PC_RESET;
        push_expected(8);

        repeat (3) @(posedge clk);
        settle();
        check("reset_valid", {64'h0, fs_to_ds_valid}, 65'h0);
        check("reset_en", {64'h0, inst_sram_en}, 65'h0);
        check("sram_size", {63'h0, inst_sram_size}, 65'h2);
        check("sram_wen", {61'h0, inst_sram_wen}, 65'h0);

        // Release reset with a ready SRAM and decode: streaming from PC_RESET.
        @(posedge clk); #1;
        reset = 1'b0; ds_allowin = 1'b1; inst_sram_addr_ok = 1'b1; c0 = cyc;
        settle();
        check("first_req_en", {64'h0, inst_sram_en}, 65'h1);
        check("first_req_addr", {33'h0, inst_sram_addr}, {33'h0, PC_RESET});
        repeat (6) idle();
        settle();
        if (ds_log.size() < 3) begin
            n_checks++;
            $display("FAIL stream_start: got %0d entries expected at least 3", ds_log.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                check("stream_cycle", 65'(ds_log[i].cyc), 65'(c0 + 2 + i));
                check("stream_pc", {33'h0, ds_log[i].bus[31:0]}, {33'h0, PC_RESET + 32'(4 * i)});
            end
        end

        // Decode stalled: queue fills to IBUF_DEPTH, requests stop, then drains in order.
        allow_pct = 0;
        drive(1'b0, 1'b0, 1'b1, 1'b0, 32'h1c00_0200, 32'h0, 32'h0);
        settle();
        a0 = acc_log.size();
        repeat (12) idle();
        settle();
        check("stall_accepts", 65'(acc_log.size() - a0), 65'(IBUF_DEPTH));
        check("stall_en_low", {64'h0, inst_sram_en}, 65'h0);
        p0 = ds_log.size();
        allow_pct = 100;
        repeat (8) idle();
        settle();
        check("stall_release_count", {64'h0, (ds_log.size() - p0) >= IBUF_DEPTH}, 65'h1);
        if (ds_log.size() > p0) check("stall_release_pc", {33'h0, ds_log[p0].bus[31:0]}, {33'h0, 32'h1c00_0200});

        // Two requests in flight when a branch redirects: both responses are dropped.
        data_pct = 0;
        repeat (4) idle();
        settle();
        check("two_outstanding", 65'(pend.size()), 65'(MAX_OUT));
        drive(1'b0, 1'b0, 1'b1, 1'b0, 32'h1c00_0100, 32'h0, 32'h0);
        p0 = ds_log.size();
        data_pct = 100;
        repeat (10) idle();
        settle();
        if (ds_log.size() > p0) check("late_drop_pc", {32'h0, ds_log[p0].bus[64], ds_log[p0].bus[31:0]}, {33'h0, 32'h1c00_0100});
        else begin n_checks++; $display("FAIL late_drop_pc: got no entry expected 1c000100"); end

        // Redirect overrides br_stall; request to target in the very next cycle.
        addr_pct = 0;
        repeat (8) idle();
        drive(1'b0, 1'b0, 1'b1, 1'b1, 32'h1c00_0300, 32'h0, 32'h0);
        addr_pct = 100;
        idle();
        settle();
        check("redir_stall_en", {64'h0, inst_sram_en}, 65'h1);
        check("redir_stall_addr", {33'h0, inst_sram_addr}, {33'h0, 32'h1c00_0300});

        // Exception beats branch; ertn beats branch.
        a0 = acc_log.size();
        drive(1'b1, 1'b0, 1'b1, 1'b0, 32'h1c00_0400, 32'h1c00_0800, 32'h1c00_0900);
        repeat (5) idle();
        settle();
        if (acc_log.size() > a0) check("ex_priority", {33'h0, acc_log[a0]}, {33'h0, 32'h1c00_0800});
        else begin n_checks++; $display("FAIL ex_priority: got no request expected 1c000800"); end
        a0 = acc_log.size();
        drive(1'b0, 1'b1, 1'b1, 1'b0, 32'h1c00_0400, 32'h1c00_0800, 32'h1c00_0900);
        repeat (5) idle();
        settle();
        if (acc_log.size() > a0) check("ertn_priority", {33'h0, acc_log[a0]}, {33'h0, 32'h1c00_0900});
        else begin n_checks++; $display("FAIL ertn_priority: got no request expected 1c000900"); end

        // Misaligned branch target: one adef entry, no SRAM request, hold until redirect.
        s0 = adef_seen;
        drive(1'b0, 1'b0, 1'b1, 1'b0, 32'h1c00_0102, 32'h0, 32'h0);
        settle();
        a0 = acc_log.size();
        repeat (10) idle();
        settle();
        check("adef_count", 65'(adef_seen - s0), 65'h1);
        check("adef_no_request", 65'(acc_log.size() - a0), 65'h0);
        drive(1'b0, 1'b0, 1'b1, 1'b0, 32'h1c00_0600, 32'h0, 32'h0);
        repeat (4) idle();

        // Slow responses (3 cycles) with a redirect while addr_ok is high.
        lat_min = 3;
        repeat (6) idle();
        drive(1'b0, 1'b0, 1'b1, 1'b0, 32'h1c00_0500, 32'h0, 32'h0);
        p0 = ds_log.size();
        repeat (20) idle();
        settle();
        if (ds_log.size() > p0) check("slow_discard_pc", {33'h0, ds_log[p0].bus[31:0]}, {33'h0, 32'h1c00_0500});
        else begin n_checks++; $display("FAIL slow_discard_pc: got no entry expected 1c000500"); end

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            if (i % 50 == 0) begin
                addr_pct  = int'($urandom_range(100, 30));
                data_pct  = int'($urandom_range(100, 30));
                allow_pct = int'($urandom_range(100, 20));
                stall_pct = int'($urandom_range(20));
                lat_min   = int'($urandom_range(3, 1));
            end
            if ($urandom_range(99) < 4) begin
                int kind;
                kind = int'($urandom_range(7, 1));
                drive(kind[2], kind[1], kind[0], 1'b0, rand_target(), rand_target(), rand_target());
            end else begin
                idle();
            end
        end
        settle();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
